data_memory_arbiter: RTL and testbench

DATA_MEMORY_ARBITER -- requirements
Module: data_memory_arbiter

---
 rtl/data_memory_arbiter.sv | 117 +++++++++++
 tb/tb_data_memory_arbiter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_arbiter.sv
// -----------------------------------------------------------------------------
// data_memory_arbiter
// Two-requester round-robin arbiter in front of a single-port data memory.
// A sampled request becomes a one-cycle grant; the memory command issued with
// the grant is registered, and read data comes back one cycle later.
// A requester cannot be granted two cycles in a row, so a lone requester gets
// every other cycle while two requesters interleave back-to-back.
//
// Ports
//   Clk, Reset                  clock, asynchronous active-high reset
//   Req0/1, Write0/1            request and direction (1 = write) per requester
//   Adress0/1, WriteData0/1     word address and write data per requester
//   Gnt0/1                      one-cycle grant pulse
//   RdValid0/1                  one-cycle read-data-valid pulse
//   Err0/1                      one-cycle out-of-range pulse (with the grant)
//   RdData                      read data, straight from MemReadData
//   MemWrite/MemRead            memory command strobes
//   MemAdress/MemWriteData      memory address and write data
//   MemReadData                 memory read data, one cycle after MemRead
// -----------------------------------------------------------------------------
module data_memory_arbiter #(
    parameter int MemSize = 4096
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Req0,
    input  logic        Req1,
    input  logic        Write0,
    input  logic        Write1,
    input  logic [31:0] Adress0,
    input  logic [31:0] Adress1,
    input  logic [31:0] WriteData0,
    input  logic [31:0] WriteData1,
    output logic        Gnt0,
    output logic        Gnt1,
    output logic        RdValid0,
    output logic        RdValid1,
    output logic        Err0,
    output logic        Err1,
    output logic [31:0] RdData,
    output logic        MemWrite,
    output logic        MemRead,
    output logic [31:0] MemAdress,
    output logic [31:0] MemWriteData,
    input  logic [31:0] MemReadData
);

    typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

    localparam logic [31:0] MemLimit = 32'(MemSize);

    state_t      state, nextState;
    logic        last;          // requester served most recently
    logic        elig0, elig1;
    logic        selWrite;
    logic [31:0] selAdress, selData;
    logic        inRange;

    // A requester whose grant is showing this cycle is not eligible again.
    always_comb begin
        elig0     = Req0 && (state != GRANT0);
        elig1     = Req1 && (state != GRANT1);
        nextState = IDLE;
        if (elig0 && elig1)
            nextState = last ? GRANT0 : GRANT1;
        else if (elig0)
            nextState = GRANT0;
        else if (elig1)
            nextState = GRANT1;
        selWrite  = (nextState == GRANT1) ? Write1     : Write0;
        selAdress = (nextState == GRANT1) ? Adress1    : Adress0;
        selData   = (nextState == GRANT1) ? WriteData1 : WriteData0;
        inRange   = selAdress < MemLimit;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state        <= IDLE;
            last         <= 1'b1;
            RdValid0     <= 1'b0;
            RdValid1     <= 1'b0;
            Err0         <= 1'b0;
            Err1         <= 1'b0;
            MemWrite     <= 1'b0;
            MemRead      <= 1'b0;
            MemAdress    <= '0;
            MemWriteData <= '0;
        end else begin
            state    <= nextState;
            // Read issued during a grant cycle returns on the following cycle.
            RdValid0 <= (state == GRANT0) && MemRead;
            RdValid1 <= (state == GRANT1) && MemRead;
            Err0     <= 1'b0;
            Err1     <= 1'b0;
            MemWrite <= 1'b0;
            MemRead  <= 1'b0;
            if (nextState != IDLE) begin
                last <= (nextState == GRANT1);
                if (inRange) begin
                    MemWrite     <= selWrite;
                    MemRead      <= !selWrite;
                    MemAdress    <= selAdress;
                    MemWriteData <= selData;
                end else begin
                    // Out-of-range grant: flag it, leave the memory untouched.
                    Err0 <= (nextState == GRANT0);
                    Err1 <= (nextState == GRANT1);
                end
            end
        end
    end

    assign Gnt0   = (state == GRANT0);
    assign Gnt1   = (state == GRANT1);
    assign RdData = MemReadData;

endmodule

// File: tb/tb_data_memory_arbiter.sv
module tb_data_memory_arbiter;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Req0, Req1, Write0, Write1;
    logic [31:0] Adress0, Adress1, WriteData0, WriteData1;
    logic        Gnt0, Gnt1, RdValid0, RdValid1, Err0, Err1;
    logic [31:0] RdData;
    logic        MemWrite, MemRead;
    logic [31:0] MemAdress, MemWriteData;
    logic [31:0] MemReadData;

    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    data_memory_arbiter #(.MemSize(4096)) dut (
        .Clk(Clk), .Reset(Reset),
        .Req0(Req0), .Req1(Req1), .Write0(Write0), .Write1(Write1),
        .Adress0(Adress0), .Adress1(Adress1),
        .WriteData0(WriteData0), .WriteData1(WriteData1),
        .Gnt0(Gnt0), .Gnt1(Gnt1), .RdValid0(RdValid0), .RdValid1(RdValid1),
        .Err0(Err0), .Err1(Err1), .RdData(RdData),
        .MemWrite(MemWrite), .MemRead(MemRead),
        .MemAdress(MemAdress), .MemWriteData(MemWriteData),
        .MemReadData(MemReadData)
    );

    // Environment memory: synchronous read, data valid the cycle after MemRead.
    logic [31:0] tbMem [0:4095];
    logic        initMem;
    always @(posedge Clk) begin
        if (initMem) begin
            for (int i = 0; i < 4096; i++) tbMem[i] <= 32'h0;
            MemReadData <= 32'h0;
        end else begin
            if (MemWrite) tbMem[MemAdress[11:0]] <= MemWriteData;
            if (MemRead)  MemReadData <= tbMem[MemAdress[11:0]];
        end
    end

    // Reference model: who should hold the bus this cycle and what it issued.
    logic [31:0] refMem [0:4095];
    int          mLast, mGnt;
    logic [1:0]  eGnt, eErr, eRdV;
    logic        eMemW, eMemR;
    logic [31:0] eAddr, eWData, eRdData;

    task automatic modelReset();
        mLast = 1; mGnt = -1;
        eGnt = 0; eErr = 0; eRdV = 0; eMemW = 0; eMemR = 0;
        eAddr = 0; eWData = 0; eRdData = 0;
    endtask

    // Called right after a rising edge, with the inputs that edge sampled.
    task automatic modelEdge();
        int pick;
        logic e0, e1, w;
        logic [31:0] a, d;
        eRdV = 0;
        if (mGnt >= 0 && eMemR) begin
            eRdV[mGnt] = 1'b1;
            eRdData = refMem[eAddr[11:0]];
        end
        if (eMemW) refMem[eAddr[11:0]] = eWData;
        e0 = Req0 && (mGnt != 0);
        e1 = Req1 && (mGnt != 1);
        pick = -1;
        if (e0 && e1)  pick = (mLast == 0) ? 1 : 0;
        else if (e0)   pick = 0;
        else if (e1)   pick = 1;
        mGnt = pick;
        eGnt = 0; eErr = 0; eMemW = 0; eMemR = 0;
        if (pick >= 0) begin
            mLast = pick;
            eGnt[pick] = 1'b1;
            a = (pick == 1) ? Adress1 : Adress0;
            w = (pick == 1) ? Write1 : Write0;
            d = (pick == 1) ? WriteData1 : WriteData0;
            if (a < 32'd4096) begin
                eMemW = w; eMemR = !w; eAddr = a; eWData = d;
            end else begin
                eErr[pick] = 1'b1;
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic checkAll();
        check("gnt0", {31'b0, Gnt0}, {31'b0, eGnt[0]});
        check("gnt1", {31'b0, Gnt1}, {31'b0, eGnt[1]});
        check("err0", {31'b0, Err0}, {31'b0, eErr[0]});
        check("err1", {31'b0, Err1}, {31'b0, eErr[1]});
        check("rdvalid0", {31'b0, RdValid0}, {31'b0, eRdV[0]});
        check("rdvalid1", {31'b0, RdValid1}, {31'b0, eRdV[1]});
        check("memwrite", {31'b0, MemWrite}, {31'b0, eMemW});
        check("memread", {31'b0, MemRead}, {31'b0, eMemR});
        check("memadress", MemAdress, eAddr);
        check("memwritedata", MemWriteData, eWData);
        if (eRdV != 0) check("rddata", RdData, eRdData);
        check("excl_gnt", {31'b0, Gnt0 & Gnt1}, 32'h0);
        check("excl_rdv", {31'b0, RdValid0 & RdValid1}, 32'h0);
        check("excl_mem", {31'b0, MemWrite & MemRead}, 32'h0);
    endtask

    task automatic step();
        @(posedge Clk);
        modelEdge();
        #1;
        checkAll();
    endtask

    task automatic checkAllZero(input string tag);
        check({tag, "_outs"}, {26'b0, Gnt0, Gnt1, RdValid0, RdValid1, Err0, Err1}, 32'h0);
        check({tag, "_strobes"}, {30'b0, MemWrite, MemRead}, 32'h0);
        check({tag, "_adress"}, MemAdress, 32'h0);
        check({tag, "_wdata"}, MemWriteData, 32'h0);
    endtask

    // Reset asserted asynchronously; outputs must clear before any edge.
    task automatic doReset();
        Reset = 1'b1;
        #1;
        checkAllZero("reset");
        modelReset();
        @(posedge Clk);
        #1;
        Reset = 1'b0;
    endtask

    task automatic idleInputs();
        Req0 = 0; Req1 = 0; Write0 = 0; Write1 = 0;
        Adress0 = 0; Adress1 = 0; WriteData0 = 0; WriteData1 = 0;
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) refMem[i] = 32'h0;
        idleInputs();
        initMem = 1'b1;
        Reset = 1'b1;
        #1;
        checkAllZero("por");
        modelReset();
        @(posedge Clk);
        #1;
        initMem = 1'b0;
        Reset = 1'b0;
        step();

        // Single write from requester 0.
        Req0 = 1; Write0 = 1; Adress0 = 5; WriteData0 = 32'hA5;
        step();
        check("wr_gnt0", {31'b0, Gnt0}, 32'h1);
        check("wr_memwrite", {31'b0, MemWrite}, 32'h1);
        check("wr_adress", MemAdress, 32'd5);
        check("wr_data", MemWriteData, 32'hA5);
        idleInputs();
        step();
        check("wr_no_rdvalid0", {31'b0, RdValid0}, 32'h0);

        // Read back through requester 1.
        Req1 = 1; Write1 = 0; Adress1 = 5;
        step();
        check("rd_gnt1", {31'b0, Gnt1}, 32'h1);
        check("rd_memread", {31'b0, MemRead}, 32'h1);
        idleInputs();
        step();
        check("rd_rdvalid1", {31'b0, RdValid1}, 32'h1);
        check("rd_rddata", RdData, 32'hA5);
        step();

        // Both requesting from reset: strict alternation starting with 0.
        doReset();
        Req0 = 1; Req1 = 1; Write0 = 1; Write1 = 1;
        Adress0 = 10; Adress1 = 11; WriteData0 = 32'h1111; WriteData1 = 32'h2222;
        for (int i = 0; i < 6; i++) begin
            step();
            check("rr_gnt0", {31'b0, Gnt0}, (i % 2 == 0) ? 32'h1 : 32'h0);
            check("rr_gnt1", {31'b0, Gnt1}, (i % 2 == 1) ? 32'h1 : 32'h0);
        end
        idleInputs();
        step();
        step();

        // Out of range at exactly MemSize.
        Req0 = 1; Write0 = 0; Adress0 = 32'd4096;
        step();
        check("oor_gnt0", {31'b0, Gnt0}, 32'h1);
        check("oor_err0", {31'b0, Err0}, 32'h1);
        check("oor_memread", {31'b0, MemRead}, 32'h0);
        idleInputs();
        step();
        check("oor_no_rdvalid0", {31'b0, RdValid0}, 32'h0);
        check("oor_err_clear", {31'b0, Err0}, 32'h0);
        // Last in-range word.
        Req1 = 1; Write1 = 0; Adress1 = 32'd4095;
        step();
        check("edge_err1", {31'b0, Err1}, 32'h0);
        check("edge_memread", {31'b0, MemRead}, 32'h1);
        idleInputs();
        step();
        step();

        // Lone requester held high: grant every other cycle.
        Req0 = 1; Write0 = 0; Adress0 = 5;
        for (int i = 0; i < 6; i++) begin
            step();
            check("solo_gnt0", {31'b0, Gnt0}, (i % 2 == 0) ? 32'h1 : 32'h0);
        end
        idleInputs();
        step();
        step();

        // Reset during the grant cycle of a read discards the read.
        Req0 = 1; Write0 = 0; Adress0 = 5;
        step();
        check("midrst_gnt0", {31'b0, Gnt0}, 32'h1);
        idleInputs();
        doReset();
        for (int i = 0; i < 3; i++) begin
            step();
            check("midrst_no_rdvalid0", {31'b0, RdValid0}, 32'h0);
        end

        // Randomized traffic against the model.
        for (int i = 0; i < 500; i++) begin
            Req0 = ($urandom_range(0, 9) < 6);
            Req1 = ($urandom_range(0, 9) < 6);
            Write0 = $urandom_range(0, 1) == 1;
            Write1 = $urandom_range(0, 1) == 1;
            case ($urandom_range(0, 7))
                0:       Adress0 = 32'd4096 + $urandom_range(0, 100);
                1:       Adress0 = 32'd4095;
                default: Adress0 = $urandom_range(0, 15);
            endcase
            case ($urandom_range(0, 7))
                0:       Adress1 = 32'd4096 + $urandom_range(0, 100);
                1:       Adress1 = 32'd4095;
                default: Adress1 = $urandom_range(0, 15);
            endcase
            WriteData0 = $urandom;
            WriteData1 = $urandom;
            step();
        end
        idleInputs();
        step();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
